alu_regfile_core: RTL and testbench
===================================

Name: alu_regfile_core

Overview:
- Execution core of the SPARC-subset datapath.
- Contains a windowed 32-bit register file, a combinational 32-bit ALU fed by register-file port A, and the trap-base adder (TB adder).
- Sits between the IR/operand muxes and the PSR/nPC/MDR/MAR registers.
- The ALU's NZVC flags feed the PSR; the TB adder output feeds the nPC mux.

Parameters:
- NWINDOWS, 4, number of register windows; power of two; CWP width is log2(NWINDOWS).
- DW, 32, data width.

Ports:
- Clk  in  1  single system clock; all state updates on rising edge.
- Clr  in  1  reset; synchronous, active-low.
- cwp  in  log2(NWINDOWS)  current window pointer.
- ra  in  5  read address, port A.
- rb  in  5  read address, port B.
- rc  in  5  write address.
- rf_cin  in  DW  write data.
- rfe_n  in  1  write enable, active-low.
- rf_aout  out  DW  port A read data; also ALU operand A.
- rf_bout  out  DW  port B read data.
- alu_b  in  DW  ALU operand B (selected externally).
- alu_op  in  6  ALU opcode, SPARC op3 encoding.
- alu_cin  in  1  carry in (PSR C) for ADDX/SUBX.
- alu_out  out  DW  ALU result.
- n, z, v, c  out  1 each  condition flags.
- tbr_in  in  DW  trap base register value.
- tb_add_en  in  1  TB adder enable, active-high.
- tb_add_out  out  DW  trap vector address.

Behaviour:
Physical register file:
- 8 globals plus 16*NWINDOWS windowed registers (72 for NWINDOWS=4).
- r0..r7 map to globals g0..g7.
- r8..r31 map to windowed index 8 + ((16*cwp + (r-8)) mod 16*NWINDOWS).
- Consequence: ins (r24..r31) of window w alias outs (r8..r15) of window (w+1) mod NWINDOWS; cwp=NWINDOWS-1 wraps to window 0.

Reads:
- Combinational, for ra and rb independently.
- r0 always reads 0.

Writes:
- On rising Clk with Clr=1 and rfe_n=0, rf_cin is written to the register mapped by (cwp, rc).
- Writes to r0 are discarded.
- Both ports may read the same register.

Reset:
- On rising Clk with Clr=0, every physical register clears to 0.
- Reset has priority over a simultaneous write.
- A reset mid-sequence discards that cycle's write.
- After reset, rf_aout = rf_bout = 0.

ALU (purely combinational, zero latency):
- A = rf_aout, B = alu_b.
- Opcodes (cc variants 0x10..0x17, 0x18, 0x1C compute identically to the base op):
  - 0x00 ADD: A+B.
  - 0x01 AND.
  - 0x02 OR.
  - 0x03 XOR.
  - 0x04 SUB: A-B.
  - 0x05 ANDN: A&~B.
  - 0x06 ORN: A|~B.
  - 0x07 XNOR.
  - 0x08 ADDX: A+B+alu_cin.
  - 0x0C SUBX: A-B-alu_cin.
  - 0x25 SLL.
  - 0x26 SRL.
  - 0x27 SRA, shift amount B[4:0].
  - 0x3A pass B.
- Any other opcode: alu_out=0, all flags 0.

Flags (always driven; the PSR decides whether to latch):
- N = alu_out[31].
- Z = (alu_out==0).
- Add: C = carry out of bit 31; V = (A31==B31)&&(R31!=A31).
- Sub: C = borrow; V = (A31!=B31)&&(R31!=A31).
- Logic and shift ops: V=C=0.

TB adder:
- tb_add_en=1: tb_add_out = {tbr_in[31:4], 4'b0000}.
- tb_add_en=0: tb_add_out = 0.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: if rfe_n=0, Clr=1, rc!=0 and (cwp, rc) maps to the same physical register as ra (or rb), that read port returns rf_cin combinationally in the same cycle.
- Undefined: reads return stored contents only; new data is visible after the edge.

Decomposition:
- Shared package alu_regfile_pkg holds:
  - op3 opcode localparams (OP_ADD..OP_SRA, OP_PASSB).
  - the flag bit-index constants.
  - function phys_index(cwp, r).
- One natural sub-module: alu_regfile_alu (combinational ALU plus flags). Register file and TB adder stay inline.

Test Plan:
- Reset and r0:
  - Clr=0 one edge; every (cwp, r) reads 0.
  - Write r0=0xFFFFFFFF; reads 0.
- Write and add, cwp=0:
  - Write r17=0xA2044012 and r18=0xA2044012.
  - ra=17, rb=18, alu_b=rf_bout, op=0x10 -> alu_out=0x44088024, N=0 Z=0 V=1 C=1.
  - Write alu_out to r17 -> r17 reads 0x44088024.
- Window overlap:
  - cwp=1, write r8=0x12345678 -> cwp=0, r24 reads 0x12345678.
  - cwp=3, write r24=0xCAFEF00D -> cwp=0, r8 reads 0xCAFEF00D.
  - r16 at cwp=0 and cwp=1 is independent.
- Sub flags and carry ops:
  - A=5, B=5, op SUB -> 0, Z=1, C=0.
  - A=0, B=1 -> 0xFFFFFFFF, N=1, C=1.
  - ADDX with A=1, B=1, cin=1 -> 3.
  - SRA of 0x80000000 by 4 -> 0xF8000000.
- TB adder:
  - tbr_in=0x0000123F, en=1 -> 0x00001230.
  - en=0 -> 0.
- Reset priority:
  - Clr=0 and rfe_n=0 on the same edge writing r17=0xDEAD -> r17 reads 0.
  - Bypass check (with RF_WRITE_BYPASS_EN): ra=rc=17, rf_cin=0xBEEF, rfe_n=0 -> rf_aout=0xBEEF before the edge.

Source files
------------

// File: rtl/alu_regfile_pkg.sv
// Shared definitions for the alu_regfile_core execution slice.
//   - SPARC op3 opcode constants understood by the ALU
//   - bit positions of the N/Z/V/C flags inside the ALU flag vector
//   - phys_index(): maps (cwp, architectural register) to a physical
//     register-file slot, implementing the overlapping window scheme
package alu_regfile_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_AND   = 6'h01;
  localparam logic [5:0] OP_OR    = 6'h02;
  localparam logic [5:0] OP_XOR   = 6'h03;
  localparam logic [5:0] OP_SUB   = 6'h04;
  localparam logic [5:0] OP_ANDN  = 6'h05;
  localparam logic [5:0] OP_ORN   = 6'h06;
  localparam logic [5:0] OP_XNOR  = 6'h07;
  localparam logic [5:0] OP_ADDX  = 6'h08;
  localparam logic [5:0] OP_SUBX  = 6'h0C;
  localparam logic [5:0] OP_SLL   = 6'h25;
  localparam logic [5:0] OP_SRL   = 6'h26;
  localparam logic [5:0] OP_SRA   = 6'h27;
  localparam logic [5:0] OP_PASSB = 6'h3A;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int NFLAGS = 4;

  // Globals r0..r7 occupy slots 0..7. Windowed registers live in a ring of
  // 16*nwindows slots starting at 8; each window advances the ring by 16, so
  // the ins of window w land on the same slots as the outs of window w+1.
  function automatic int unsigned phys_index(input int unsigned cwp,
                                             input logic [4:0]   r,
                                             input int unsigned nwindows);
    int unsigned rr;
    rr = {27'd0, r};
    if (rr < 8) return rr;
    return 8 + ((16 * cwp + rr - 8) % (16 * nwindows));
  endfunction

endpackage

// File: rtl/alu_regfile_alu.sv
// Combinational 32-bit ALU with SPARC-style condition flags.
// Ports:
//   a, b    : operands (a comes from register-file port A)
//   op      : SPARC op3 code; cc variants compute like their base op
//   cin     : carry in for ADDX/SUBX
//   result  : ALU result (0 for unsupported opcodes)
//   flags   : {N,Z,V,C} at FLAG_* positions (all 0 for unsupported opcodes)
module alu_regfile_alu
  import alu_regfile_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     b,
  input  logic [5:0]        op,
  input  logic              cin,
  output logic [DW-1:0]     result,
  output logic [NFLAGS-1:0] flags
);

  logic signed [DW-1:0] a_s;
  logic [5:0]           base_op;
  logic [DW:0]          wide;
  logic                 carry_in;
  logic                 carry;
  logic                 ovf;
  logic                 valid;

  assign a_s = a;

  always_comb begin
    // op3 0x10..0x1F are the cc-setting twins of 0x00..0x0F; folding bit 4
    // away leaves the undefined twins (0x19.. etc.) on undefined base codes.
    base_op  = (op[5:4] == 2'b01) ? {2'b00, op[3:0]} : op;
    carry_in = cin & ((base_op == OP_ADDX) | (base_op == OP_SUBX));
    wide     = '0;
    result   = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    valid    = 1'b1;
    case (base_op)
      OP_ADD, OP_ADDX: begin
        wide   = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, carry_in};
        result = wide[DW-1:0];
        carry  = wide[DW];
        ovf    = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      OP_SUB, OP_SUBX: begin
        // Bit DW of the extended difference is the borrow.
        wide   = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, carry_in};
        result = wide[DW-1:0];
        carry  = wide[DW];
        ovf    = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_ANDN:  result = a & ~b;
      OP_ORN:   result = a | ~b;
      OP_XNOR:  result = ~(a ^ b);
      OP_SLL:   result = a << b[4:0];
      OP_SRL:   result = a >> b[4:0];
      OP_SRA:   result = a_s >>> b[4:0];
      OP_PASSB: result = b;
      default:  valid  = 1'b0;
    endcase

    flags = '0;
    if (valid) begin
      flags[FLAG_N] = result[DW-1];
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_V] = ovf;
      flags[FLAG_C] = carry;
    end
  end

endmodule

// File: rtl/alu_regfile_core.sv
// Execution core: windowed register file, ALU on port A, trap-base adder.
// Ports:
//   Clk, Clr        : clock; synchronous active-low reset (clears all regs)
//   cwp             : current window pointer
//   ra, rb          : combinational read addresses -> rf_aout, rf_bout
//   rc, rf_cin      : write address / data, written when rfe_n is low
//   alu_b, alu_op, alu_cin : ALU operand B, op3 code, carry in
//   alu_out, n/z/v/c: ALU result and condition flags
//   tbr_in, tb_add_en, tb_add_out : trap vector = tbr_in with low nibble 0
// Build option: RF_WRITE_BYPASS_EN forwards a pending write to matching
// read ports in the same cycle; without it reads show stored contents only.
module alu_regfile_core
  import alu_regfile_pkg::*;
#(
  parameter int NWINDOWS = 4,
  parameter int DW       = 32
) (
  input  logic                        Clk,
  input  logic                        Clr,
  input  logic [$clog2(NWINDOWS)-1:0] cwp,
  input  logic [4:0]                  ra,
  input  logic [4:0]                  rb,
  input  logic [4:0]                  rc,
  input  logic [DW-1:0]               rf_cin,
  input  logic                        rfe_n,
  output logic [DW-1:0]               rf_aout,
  output logic [DW-1:0]               rf_bout,
  input  logic [DW-1:0]               alu_b,
  input  logic [5:0]                  alu_op,
  input  logic                        alu_cin,
  output logic [DW-1:0]               alu_out,
  output logic                        n,
  output logic                        z,
  output logic                        v,
  output logic                        c,
  input  logic [DW-1:0]               tbr_in,
  input  logic                        tb_add_en,
  output logic [DW-1:0]               tb_add_out
);

  localparam int NREGS = 8 + 16 * NWINDOWS;
  localparam int PW    = $clog2(NREGS);

  logic [DW-1:0]     regs [NREGS];
  logic [PW-1:0]     a_idx;
  logic [PW-1:0]     b_idx;
  logic [PW-1:0]     c_idx;
  logic [DW-1:0]     a_store;
  logic [DW-1:0]     b_store;
  logic [NFLAGS-1:0] flags;

  assign a_idx = PW'(phys_index(32'(cwp), ra, NWINDOWS));
  assign b_idx = PW'(phys_index(32'(cwp), rb, NWINDOWS));
  assign c_idx = PW'(phys_index(32'(cwp), rc, NWINDOWS));

  // Slot 0 is never written, but r0 is forced to zero on the read side too.
  assign a_store = (ra == 5'd0) ? '0 : regs[a_idx];
  assign b_store = (rb == 5'd0) ? '0 : regs[b_idx];

`ifdef RF_WRITE_BYPASS_EN
  logic wr_live;
  assign wr_live = !rfe_n && Clr && (rc != 5'd0);
  assign rf_aout = (wr_live && (c_idx == a_idx)) ? rf_cin : a_store;
  assign rf_bout = (wr_live && (c_idx == b_idx)) ? rf_cin : b_store;
`else
  assign rf_aout = a_store;
  assign rf_bout = b_store;
`endif

  // Register file state: reset wins over a same-edge write.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (!rfe_n && (rc != 5'd0)) begin
      regs[c_idx] <= rf_cin;
    end
  end

  alu_regfile_alu #(
    .DW(DW)
  ) u_alu (
    .a      (rf_aout),
    .b      (alu_b),
    .op     (alu_op),
    .cin    (alu_cin),
    .result (alu_out),
    .flags  (flags)
  );

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  assign tb_add_out = tb_add_en ? {tbr_in[DW-1:4], 4'b0000} : '0;

endmodule

// File: tb/tb_alu_regfile_core.sv
module tb_alu_regfile_core;

  logic        Clk;
  logic        Clr;
  logic [1:0]  cwp;
  logic [4:0]  ra, rb, rc;
  logic [31:0] rf_cin;
  logic        rfe_n;
  logic [31:0] rf_aout, rf_bout;
  logic [31:0] alu_b;
  logic [5:0]  alu_op;
  logic        alu_cin;
  logic [31:0] alu_out;
  logic        n, z, v, c;
  logic [31:0] tbr_in;
  logic        tb_add_en;
  logic [31:0] tb_add_out;

  int errors = 0;
  int checks = 0;

  alu_regfile_core #(.NWINDOWS(4), .DW(32)) dut (
    .Clk(Clk), .Clr(Clr), .cwp(cwp), .ra(ra), .rb(rb), .rc(rc),
    .rf_cin(rf_cin), .rfe_n(rfe_n), .rf_aout(rf_aout), .rf_bout(rf_bout),
    .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin), .alu_out(alu_out),
    .n(n), .z(z), .v(v), .c(c),
    .tbr_in(tbr_in), .tb_add_en(tb_add_en), .tb_add_out(tb_add_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Stimulus helper: one write through the posedge between two negedges.
  task automatic write_reg(input logic [1:0] w, input logic [4:0] r, input logic [31:0] d);
    @(negedge Clk);
    cwp = w; rc = r; rf_cin = d; rfe_n = 1'b0;
    @(negedge Clk);
    rfe_n = 1'b1;
  endtask

  // Stimulus helper: present a read on port A (and B) and let it settle.
  task automatic set_read(input logic [1:0] w, input logic [4:0] a, input logic [4:0] b);
    @(negedge Clk);
    cwp = w; ra = a; rb = b;
    #1;
  endtask

  task automatic test_reset();
    write_reg(2'd0, 5'd5, 32'h1111_2222);
    write_reg(2'd2, 5'd20, 32'h3333_4444);
    @(negedge Clk);
    Clr = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int r = 0; r < 32; r++) begin
        set_read(2'(w), 5'(r), 5'(31 - r));
        checks++;
        if (rf_aout !== 32'h0 || rf_bout !== 32'h0) begin
          errors++;
          $display("FAIL reset_clear w=%0d r=%0d: a=%h b=%h required 0", w, r, rf_aout, rf_bout);
        end
      end
    end
  endtask

  task automatic test_r0();
    write_reg(2'd0, 5'd0, 32'hFFFF_FFFF);
    set_read(2'd0, 5'd0, 5'd0);
    checks++;
    if (rf_aout !== 32'h0 || rf_bout !== 32'h0) begin
      errors++;
      $display("FAIL r0_write: a=%h b=%h required 0", rf_aout, rf_bout);
    end
  endtask

  task automatic test_write_add();
    write_reg(2'd0, 5'd17, 32'hA204_4012);
    write_reg(2'd0, 5'd18, 32'hA204_4012);
    alu_b = 32'hA204_4012; alu_op = 6'h10; alu_cin = 1'b0;
    set_read(2'd0, 5'd17, 5'd18);
    checks++;
    if (rf_bout !== 32'hA204_4012) begin
      errors++;
      $display("FAIL read_r18: got %h required a2044012", rf_bout);
    end
    checks++;
    if (alu_out !== 32'h4408_8024) begin
      errors++;
      $display("FAIL addcc_result: got %h required 44088024", alu_out);
    end
    checks++;
    if ({n, z, v, c} !== 4'b0011) begin
      errors++;
      $display("FAIL addcc_flags: nzvc=%b required 0011", {n, z, v, c});
    end
    write_reg(2'd0, 5'd17, 32'h4408_8024);
    set_read(2'd0, 5'd17, 5'd18);
    checks++;
    if (rf_aout !== 32'h4408_8024) begin
      errors++;
      $display("FAIL writeback_r17: got %h required 44088024", rf_aout);
    end
  endtask

  task automatic test_window_overlap();
    write_reg(2'd1, 5'd8, 32'h1234_5678);
    set_read(2'd0, 5'd24, 5'd8);
    checks++;
    if (rf_aout !== 32'h1234_5678) begin
      errors++;
      $display("FAIL overlap_out_in: got %h required 12345678", rf_aout);
    end
    write_reg(2'd3, 5'd24, 32'hCAFE_F00D);
    set_read(2'd0, 5'd8, 5'd24);
    checks++;
    if (rf_aout !== 32'hCAFE_F00D || rf_bout !== 32'h1234_5678) begin
      errors++;
      $display("FAIL overlap_wrap: a=%h b=%h required cafef00d 12345678", rf_aout, rf_bout);
    end
    write_reg(2'd0, 5'd16, 32'h0000_1111);
    write_reg(2'd1, 5'd16, 32'h0000_2222);
    set_read(2'd0, 5'd16, 5'd16);
    checks++;
    if (rf_aout !== 32'h0000_1111) begin
      errors++;
      $display("FAIL local_w0_r16: got %h required 00001111", rf_aout);
    end
    set_read(2'd1, 5'd16, 5'd16);
    checks++;
    if (rf_aout !== 32'h0000_2222) begin
      errors++;
      $display("FAIL local_w1_r16: got %h required 00002222", rf_aout);
    end
  endtask

  task automatic test_alu_ops();
    // Operand A comes from global r1.
    write_reg(2'd0, 5'd1, 32'd5);
    alu_b = 32'd5; alu_op = 6'h04; alu_cin = 1'b0;
    set_read(2'd0, 5'd1, 5'd0);
    checks++;
    if (alu_out !== 32'h0 || {n, z, v, c} !== 4'b0100) begin
      errors++;
      $display("FAIL sub_equal: out=%h nzvc=%b required 0 0100", alu_out, {n, z, v, c});
    end
    write_reg(2'd0, 5'd1, 32'd0);
    alu_b = 32'd1;
    set_read(2'd0, 5'd1, 5'd0);
    checks++;
    if (alu_out !== 32'hFFFF_FFFF || {n, z, v, c} !== 4'b1001) begin
      errors++;
      $display("FAIL sub_borrow: out=%h nzvc=%b required ffffffff 1001", alu_out, {n, z, v, c});
    end
    write_reg(2'd0, 5'd1, 32'd1);
    alu_b = 32'd1; alu_op = 6'h08; alu_cin = 1'b1;
    set_read(2'd0, 5'd1, 5'd0);
    checks++;
    if (alu_out !== 32'd3) begin
      errors++;
      $display("FAIL addx: got %h required 00000003", alu_out);
    end
    alu_op = 6'h0C;
    #1;
    checks++;
    if (alu_out !== 32'hFFFF_FFFF || c !== 1'b1) begin
      errors++;
      $display("FAIL subx: out=%h c=%b required ffffffff 1", alu_out, c);
    end
    write_reg(2'd0, 5'd1, 32'h8000_0000);
    alu_b = 32'd4; alu_op = 6'h27; alu_cin = 1'b0;
    set_read(2'd0, 5'd1, 5'd0);
    checks++;
    if (alu_out !== 32'hF800_0000 || {n, z, v, c} !== 4'b1000) begin
      errors++;
      $display("FAIL sra: out=%h nzvc=%b required f8000000 1000", alu_out, {n, z, v, c});
    end
    alu_op = 6'h26;
    #1;
    checks++;
    if (alu_out !== 32'h0800_0000) begin
      errors++;
      $display("FAIL srl: got %h required 08000000", alu_out);
    end
    alu_b = 32'h0000_F0F0; alu_op = 6'h15;
    #1;
    checks++;
    if (alu_out !== 32'h8000_0000) begin
      errors++;
      $display("FAIL andncc: got %h required 80000000", alu_out);
    end
    alu_op = 6'h3A;
    #1;
    checks++;
    if (alu_out !== 32'h0000_F0F0) begin
      errors++;
      $display("FAIL passb: got %h required 0000f0f0", alu_out);
    end
    alu_op = 6'h09;
    #1;
    checks++;
    if (alu_out !== 32'h0 || {n, z, v, c} !== 4'b0000) begin
      errors++;
      $display("FAIL bad_op: out=%h nzvc=%b required 0 0000", alu_out, {n, z, v, c});
    end
  endtask

  task automatic test_tb_adder();
    @(negedge Clk);
    tbr_in = 32'h0000_123F; tb_add_en = 1'b1;
    #1;
    checks++;
    if (tb_add_out !== 32'h0000_1230) begin
      errors++;
      $display("FAIL tb_add_en1: got %h required 00001230", tb_add_out);
    end
    tb_add_en = 1'b0;
    #1;
    checks++;
    if (tb_add_out !== 32'h0) begin
      errors++;
      $display("FAIL tb_add_en0: got %h required 0", tb_add_out);
    end
  endtask

  task automatic test_reset_priority();
    write_reg(2'd0, 5'd17, 32'h0000_5555);
    @(negedge Clk);
    cwp = 2'd0; rc = 5'd17; rf_cin = 32'h0000_DEAD; rfe_n = 1'b0; Clr = 1'b0;
    @(negedge Clk);
    rfe_n = 1'b1; Clr = 1'b1;
    set_read(2'd0, 5'd17, 5'd17);
    checks++;
    if (rf_aout !== 32'h0) begin
      errors++;
      $display("FAIL reset_over_write: got %h required 0", rf_aout);
    end
  endtask

  task automatic test_bypass();
    write_reg(2'd0, 5'd17, 32'h0000_1234);
    @(negedge Clk);
    cwp = 2'd0; ra = 5'd17; rb = 5'd18; rc = 5'd17; rf_cin = 32'h0000_BEEF; rfe_n = 1'b0;
    #1;
    checks++;
`ifdef RF_WRITE_BYPASS_EN
    if (rf_aout !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL bypass_pre_edge: got %h required 0000beef", rf_aout);
    end
`else
    if (rf_aout !== 32'h0000_1234) begin
      errors++;
      $display("FAIL no_bypass_pre_edge: got %h required 00001234", rf_aout);
    end
`endif
    @(negedge Clk);
    rfe_n = 1'b1;
    #1;
    checks++;
    if (rf_aout !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL post_edge_write: got %h required 0000beef", rf_aout);
    end
  endtask

  initial begin
    Clr = 1'b0; cwp = '0; ra = '0; rb = '0; rc = '0; rf_cin = '0; rfe_n = 1'b1;
    alu_b = '0; alu_op = '0; alu_cin = 1'b0; tbr_in = '0; tb_add_en = 1'b0;
    repeat (2) @(negedge Clk);
    Clr = 1'b1;
    test_reset();
    test_r0();
    test_write_add();
    test_window_overlap();
    test_alu_ops();
    test_tb_adder();
    test_reset_priority();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
